// File: rtl/rv_pkg.sv
// Shared types and constants for the RV32 front end.
package rv_pkg;
  localparam int unsigned XLEN_DEF     = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;  // ADDI x0,x0,0

  typedef enum logic [1:0] {
    FS_BOOT = 2'd0,
    FS_RUN  = 2'd1,
    FS_WAIT = 2'd2,
    FS_HALT = 2'd3
  } fetch_state_e;
endpackage

// File: rtl/instr_fetch_unit_if_id_reg.sv
// IF/ID pipeline register: load a fetched word, flush to NOP, or hold.
module if_id_reg
  import rv_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            flush,
  input  logic [XLEN-1:0] pc_in,
  input  logic [XLEN-1:0] instr_in,
  output logic [XLEN-1:0] pc_id,
  output logic [XLEN-1:0] pc_plus4_id,
  output logic [XLEN-1:0] instr_id,
  output logic            valid_id
);
  logic [XLEN-1:0] pc_q, pc_d, pc4_q, pc4_d, instr_q, instr_d;
  logic            valid_q, valid_d;

  // Flush wins over load; PC fields are kept on flush since they are don't-care when invalid.
  always_comb begin
    pc_d    = pc_q;
    pc4_d   = pc4_q;
    instr_d = instr_q;
    valid_d = valid_q;
    if (flush) begin
      instr_d = XLEN'(NOP_INSTR);
      valid_d = 1'b0;
    end else if (load) begin
      pc_d    = pc_in;
      pc4_d   = pc_in + XLEN'(4);
      instr_d = instr_in;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= '0;
      pc4_q   <= XLEN'(4);
      instr_q <= XLEN'(NOP_INSTR);
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      pc4_q   <= pc4_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

  assign pc_id       = pc_q;
  assign pc_plus4_id = pc4_q;
  assign instr_id    = instr_q;
  assign valid_id    = valid_q;
endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: PC, fetch FSM, redirect/stall handling, IF/ID register.
// Optional fetch/bubble counters enabled with `define IF_PERF_CNT_EN.
module instr_fetch_unit
  import rv_pkg::*;
#(
  parameter int unsigned     XLEN     = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF)
) (
  input  logic            CLK,
  input  logic            RESET,
  output logic [XLEN-1:0] IMEM_ADDR,
  output logic            IMEM_REQ,
  input  logic [XLEN-1:0] IMEM_INSTR,
  input  logic            IMEM_READY,
  input  logic            STALL,
  input  logic            REDIRECT,
  input  logic [XLEN-1:0] REDIRECT_PC,
  output logic [XLEN-1:0] PC_ID,
  output logic [XLEN-1:0] PC_PLUS4_ID,
  output logic [XLEN-1:0] INSTR_ID,
  output logic            VALID_ID,
  output logic            FETCH_ERR
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]     FETCH_CNT,
  output logic [31:0]     BUBBLE_CNT
`endif
);
  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            err_q, err_d;
  logic            req_q, req_d;
  logic            load, flush;

  // Priority: redirect > stall > fetch-complete; HALT ignores every input.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    err_d   = err_q;
    load    = 1'b0;
    flush   = 1'b0;
    if (state_q != FS_HALT && REDIRECT) begin
      flush = 1'b1;
      if (REDIRECT_PC[1:0] != 2'b00) begin
        err_d   = 1'b1;
        state_d = FS_HALT;
      end else begin
        pc_d    = REDIRECT_PC;
        state_d = FS_RUN;
      end
    end else begin
      case (state_q)
        FS_BOOT: state_d = FS_RUN;
        FS_RUN, FS_WAIT: begin
          if (!STALL) begin
            if (IMEM_READY) begin
              load    = 1'b1;
              pc_d    = pc_q + XLEN'(4);
              state_d = FS_RUN;
            end else begin
              flush   = 1'b1;
              state_d = FS_WAIT;
            end
          end
        end
        default: ;
      endcase
    end
    req_d = (state_d == FS_RUN) || (state_d == FS_WAIT);
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= FS_BOOT;
      pc_q    <= RESET_PC;
      err_q   <= 1'b0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      err_q   <= err_d;
      req_q   <= req_d;
    end
  end

  assign IMEM_ADDR = pc_q;
  assign IMEM_REQ  = req_q;
  assign FETCH_ERR = err_q;

  if_id_reg #(.XLEN(XLEN)) u_if_id (
    .clk        (CLK),
    .rst_n      (RESET),
    .load       (load),
    .flush      (flush),
    .pc_in      (pc_q),
    .instr_in   (IMEM_INSTR),
    .pc_id      (PC_ID),
    .pc_plus4_id(PC_PLUS4_ID),
    .instr_id   (INSTR_ID),
    .valid_id   (VALID_ID)
  );

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d, bubble_cnt_q, bubble_cnt_d;

  always_comb begin
    fetch_cnt_d  = fetch_cnt_q + 32'(load);
    bubble_cnt_d = bubble_cnt_q + 32'(flush);
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      fetch_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      fetch_cnt_q  <= fetch_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign FETCH_CNT  = fetch_cnt_q;
  assign BUBBLE_CNT = bubble_cnt_q;
`endif
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Initiator side of the instruction-memory interface: owns the PC, drives the fetch address to INSTRUCTION_MEMORY and consumes the returned word.
- Registers the word into the IF/ID pipeline register.
- Handles pipeline stall, branch/jump redirect with flush, and a memory-ready handshake, so the registered (synchronous) memory variant can be swapped in later.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- XLEN, 32, address and instruction width

Ports:
- CLK  in  1  system clock, rising edge
- RESET  in  1  asynchronous, active-low reset
- IMEM_ADDR  out  XLEN  fetch address; always equals the PC register
- IMEM_REQ  out  1  fetch request valid
- IMEM_INSTR  in  XLEN  instruction word returned for IMEM_ADDR
- IMEM_READY  in  1  IMEM_INSTR valid this cycle; tied 1 for the combinational memory
- STALL  in  1  hazard unit: hold PC and IF/ID
- REDIRECT  in  1  EX: taken branch/jump, one-cycle pulse
- REDIRECT_PC  in  XLEN  redirect target
- PC_ID  out  XLEN  PC of the instruction in IF/ID
- PC_PLUS4_ID  out  XLEN  PC_ID + 4, for JAL/JALR link
- INSTR_ID  out  XLEN  instruction in IF/ID
- VALID_ID  out  1  IF/ID holds a real instruction
- FETCH_ERR  out  1  sticky: misaligned redirect target

Behaviour:
- Reset (RESET=0, asynchronous):
  - PC=RESET_PC, state=BOOT, INSTR_ID=NOP (32'h0000_0013, ADDI x0,x0,0).
  - PC_ID=0, PC_PLUS4_ID=4, VALID_ID=0, FETCH_ERR=0, IMEM_REQ=0.
- FSM states: BOOT, RUN, WAIT, HALT.
  - BOOT: one cycle after reset release, IMEM_REQ=0, then go to RUN. This guarantees no fetch on the deassertion edge.
  - RUN/WAIT: IMEM_REQ=1. Fetch completes in a cycle with IMEM_READY=1.
  - RUN with IMEM_READY=0 -> WAIT. WAIT with IMEM_READY=1 -> RUN.
- Event priority per cycle: REDIRECT > STALL > fetch-complete.
- REDIRECT=1 (any state except HALT):
  - If REDIRECT_PC[1:0]≠0: FETCH_ERR<=1, state<=HALT, IF/ID<=NOP/VALID 0.
  - Otherwise: PC<=REDIRECT_PC, IF/ID<=NOP with VALID_ID=0, state<=RUN.
  - An in-flight word is discarded, and any IMEM_READY in the same cycle is ignored.
- STALL=1 (no redirect): PC, IF/ID and state hold, IMEM_REQ stays 1, and the returned word is discarded. The same address is refetched after the stall, which is safe because memory is side-effect free.
- Fetch-complete (RUN/WAIT, IMEM_READY=1, no STALL/REDIRECT):
  - INSTR_ID<=IMEM_INSTR, PC_ID<=PC, PC_PLUS4_ID<=PC+4, VALID_ID<=1, PC<=PC+4.
- No completion (READY=0, no stall): IF/ID<=NOP with VALID_ID=0, which inserts a bubble.
- Latency: address to IF/ID is 1 cycle with READY=1. Redirect to first valid target in IF/ID is 2 cycles.
- PC arithmetic is modulo 2^XLEN: 32'hFFFF_FFFC+4 wraps to 0, and no error is raised.
- HALT: IMEM_REQ=0, IF/ID=NOP/VALID 0, and all inputs are ignored. Only reset exits HALT.
- Reset asserted mid-WAIT or mid-stall returns all outputs to reset values immediately.

Optional Feature:
- Macro: IF_PERF_CNT_EN.
- When defined, adds two ports:
  - FETCH_CNT out 32: count of completed fetches.
  - BUBBLE_CNT out 32: count of cycles where VALID_ID<=0 was written.
  - Both reset to 0 and wrap modulo 2^32.
- When undefined, neither port nor the counter logic exists; all other behaviour is identical.

Decomposition:
- Shared package (rv_pkg):
  - NOP_INSTR constant.
  - fetch FSM state typedef (BOOT/RUN/WAIT/HALT, 2-bit).
  - XLEN default.
  - RESET_PC default.
- One natural sub-module: if_id_reg, holding PC_ID/PC_PLUS4_ID/INSTR_ID/VALID_ID.
  - Controls: load, flush (NOP), hold.
  - Async active-low reset.

Test Plan:
- Release reset, READY=1, memory returns ADDI words at 0x0,0x4,0x8 -> IMEM_REQ low 1 cycle; IMEM_ADDR 0,4,8 on successive cycles; INSTR_ID/PC_ID pairs (0x00E00413,0),(…,4) one cycle later; VALID_ID=1.
- STALL high 3 cycles at PC=0x10 -> IMEM_ADDR stays 0x10, IF/ID unchanged 3 cycles; after release, INSTR_ID of 0x10 appears once, no duplicate or skip.
- REDIRECT pulse with REDIRECT_PC=0xB4 while PC=0x20, simultaneously with STALL=1 -> next IMEM_ADDR=0xB4, VALID_ID=0, INSTR_ID=0x00000013; PC_ID=0xB4 valid 2 cycles after the pulse.
- IMEM_READY low 2 cycles at PC=0x8 -> state WAIT, two bubbles (VALID_ID=0), then INSTR_ID for 0x8; PC advances to 0xC only after completion.
- REDIRECT_PC=0x42 -> FETCH_ERR=1 sticky, IMEM_REQ=0, VALID_ID=0 forever; a further redirect to 0x40 is ignored; async reset clears FETCH_ERR to 0 with PC=RESET_PC.
- Redirect to 0xFFFF_FFFC, READY=1 -> PC_PLUS4_ID=0 and next IMEM_ADDR=0x0, no error; with IF_PERF_CNT_EN, FETCH_CNT and BUBBLE_CNT match scenario counts.
